// File: rtl/medidor_echo_pkg.sv
// Shared definitions for the ultrasonic ranging slice: state encodings and
// default timing constants reused by the display and serial stages.
package medidor_echo_pkg;

  localparam logic [3:0] INICIAL        = 4'd0;
  localparam logic [3:0] DISPARA        = 4'd1;
  localparam logic [3:0] ESPERA_TRIGGER = 4'd2;
  localparam logic [3:0] ESPERA_ECHO    = 4'd3;
  localparam logic [3:0] MEDE           = 4'd4;
  localparam logic [3:0] FINAL          = 4'd5;
  localparam logic [3:0] ERRO           = 4'd6;

  localparam int CICLOS_POR_CM_PADRAO  = 2941;
  localparam int TIMEOUT_CICLOS_PADRAO = 1250000;
  localparam int LARGURA_MEDIDA_PADRAO = 12;

  // Bits needed to hold values 0..maximo-1, never less than one.
  function automatic int largura_contador(input int maximo);
    return (maximo > 1) ? $clog2(maximo) : 1;
  endfunction

endpackage

// File: rtl/medidor_echo_contador_cm.sv
// Echo-width to centimetre converter: a tick prescaler feeding a saturating
// cm counter, plus the half-centimetre rounded result.
module medidor_echo_contador_cm
  import medidor_echo_pkg::*;
#(
  parameter int CICLOS_POR_CM  = CICLOS_POR_CM_PADRAO,
  parameter int LARGURA_MEDIDA = LARGURA_MEDIDA_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      limpa,
  input  logic                      conta,
  output logic [LARGURA_MEDIDA-1:0] cm_arred
);

  localparam int TICK_W = largura_contador(CICLOS_POR_CM);
  localparam logic [TICK_W-1:0]         TICK_MAX  = TICK_W'(CICLOS_POR_CM - 1);
  localparam logic [TICK_W-1:0]         TICK_MEIO = TICK_W'(CICLOS_POR_CM / 2);
  localparam logic [LARGURA_MEDIDA-1:0] CM_MAX    = '1;

  logic [TICK_W-1:0]         tick_q, tick_d;
  logic [LARGURA_MEDIDA-1:0] cm_q, cm_d;

  function automatic logic [LARGURA_MEDIDA-1:0] inc_sat(input logic [LARGURA_MEDIDA-1:0] v);
    return (v == CM_MAX) ? v : v + LARGURA_MEDIDA'(1);
  endfunction

  // Next-count logic: clear wins over counting.
  always_comb begin
    tick_d = tick_q;
    cm_d   = cm_q;
    if (limpa) begin
      tick_d = '0;
      cm_d   = '0;
    end else if (conta) begin
      if (tick_q == TICK_MAX) begin
        tick_d = '0;
        cm_d   = inc_sat(cm_q);
      end else begin
        tick_d = tick_q + TICK_W'(1);
        cm_d   = cm_q;
      end
    end else begin
      tick_d = tick_q;
      cm_d   = cm_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
      cm_q   <= '0;
    end else begin
      tick_q <= tick_d;
      cm_q   <= cm_d;
    end
  end

  assign cm_arred = (tick_q >= TICK_MEIO) ? inc_sat(cm_q) : cm_q;

endmodule

// File: rtl/medidor_echo.sv
// Ultrasonic ranging controller: fires gerador_pulso, times the echo pulse
// and reports distance in cm, flagging a timeout when no echo completes.
module medidor_echo
  import medidor_echo_pkg::*;
#(
  parameter int CICLOS_POR_CM  = CICLOS_POR_CM_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int LARGURA_MEDIDA = LARGURA_MEDIDA_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      medir,
  input  logic                      pronto_pulso,
  input  logic                      echo,
  output logic                      gera,
  output logic [LARGURA_MEDIDA-1:0] medida,
  output logic                      pronto,
  output logic                      erro_timeout,
  output logic                      ocupado,
  output logic [3:0]                db_estado
);

  localparam int TO_W = largura_contador(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CICLOS - 1);

  logic                      echo_m_q, echo_s_q, echo_d1_q;
  logic [3:0]                estado_q, estado_d;
  logic [TO_W-1:0]           to_q, to_d;
  logic                      gera_q, gera_d;
  logic                      pronto_q, pronto_d;
  logic                      erro_q, erro_d;
  logic                      ocupado_q, ocupado_d;
  logic [LARGURA_MEDIDA-1:0] medida_q, medida_d;
  logic                      limpa_cm, conta_cm;
  logic [LARGURA_MEDIDA-1:0] cm_arred;
  logic                      echo_sobe, echo_desce, to_fim;

  // Both edges are taken from the same synchronized copy, so width is preserved.
  assign echo_sobe  = echo_s_q & ~echo_d1_q;
  assign echo_desce = ~echo_s_q & echo_d1_q;
  assign to_fim     = (to_q == TO_MAX);

  // State transitions and timeout counter; timeout is tested before the echo fall.
  always_comb begin
    estado_d = estado_q;
    to_d     = to_q;
    limpa_cm = 1'b0;
    conta_cm = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (medir) estado_d = DISPARA;
        else       estado_d = INICIAL;
      end
      DISPARA: estado_d = ESPERA_TRIGGER;
      ESPERA_TRIGGER: begin
        if (pronto_pulso) begin
          estado_d = ESPERA_ECHO;
          to_d     = '0;
        end else begin
          estado_d = ESPERA_TRIGGER;
        end
      end
      ESPERA_ECHO: begin
        to_d = to_q + TO_W'(1);
        if (to_fim) begin
          estado_d = ERRO;
        end else if (echo_sobe) begin
          estado_d = MEDE;
          limpa_cm = 1'b1;
        end else begin
          estado_d = ESPERA_ECHO;
        end
      end
      MEDE: begin
        to_d     = to_q + TO_W'(1);
        conta_cm = 1'b1;
        if (to_fim)          estado_d = ERRO;
        else if (echo_desce) estado_d = FINAL;
        else                 estado_d = MEDE;
      end
      FINAL:   estado_d = INICIAL;
      ERRO:    estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase
  end

  // Output register inputs; gera and ocupado follow the next state to align with it.
  always_comb begin
    gera_d    = (estado_d == DISPARA);
    pronto_d  = (estado_q == FINAL);
    ocupado_d = (estado_d != INICIAL);
    if (estado_q == FINAL) medida_d = cm_arred;
    else                   medida_d = medida_q;
    if (estado_d == ERRO)                     erro_d = 1'b1;
    else if ((estado_q == INICIAL) && medir)  erro_d = 1'b0;
    else                                      erro_d = erro_q;
  end

  // Echo synchronizer and its delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m_q  <= 1'b0;
      echo_s_q  <= 1'b0;
      echo_d1_q <= 1'b0;
    end else begin
      echo_m_q  <= echo;
      echo_s_q  <= echo_m_q;
      echo_d1_q <= echo_s_q;
    end
  end

  // FSM, timeout counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      to_q      <= '0;
      gera_q    <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
      medida_q  <= '0;
    end else begin
      estado_q  <= estado_d;
      to_q      <= to_d;
      gera_q    <= gera_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
      medida_q  <= medida_d;
    end
  end

  medidor_echo_contador_cm #(
    .CICLOS_POR_CM  (CICLOS_POR_CM),
    .LARGURA_MEDIDA (LARGURA_MEDIDA)
  ) u_contador_cm (
    .clock    (clock),
    .reset    (reset),
    .limpa    (limpa_cm),
    .conta    (conta_cm),
    .cm_arred (cm_arred)
  );

  assign gera         = gera_q;
  assign pronto       = pronto_q;
  assign erro_timeout = erro_q;
  assign ocupado      = ocupado_q;
  assign medida       = medida_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_medidor_echo.sv
// Self-checking bench for medidor_echo: two instances (12-bit and 4-bit result)
// share stimulus; expected distances come from plain cm arithmetic.
module tb_medidor_echo;

  localparam int CPM  = 10;
  localparam int TOUT = 500;
  localparam int W    = 12;
  localparam int W4   = 4;

  logic          clock, reset, medir, pronto_pulso, echo;
  logic          gera, pronto, erro_timeout, ocupado;
  logic [W-1:0]  medida;
  logic [3:0]    db_estado;
  logic          gera4, pronto4, erro4, ocupado4;
  logic [W4-1:0] medida4;
  logic [3:0]    db4;

  int checks = 0;
  int errors = 0;
  int gera_cnt = 0;
  int gen_cnt = 0;
  int exp_medida = 0;
  int exp_medida4 = 0;

  medidor_echo #(.CICLOS_POR_CM(CPM), .TIMEOUT_CICLOS(TOUT), .LARGURA_MEDIDA(W)) dut (
    .clock(clock), .reset(reset), .medir(medir), .pronto_pulso(pronto_pulso), .echo(echo),
    .gera(gera), .medida(medida), .pronto(pronto), .erro_timeout(erro_timeout),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  medidor_echo #(.CICLOS_POR_CM(CPM), .TIMEOUT_CICLOS(TOUT), .LARGURA_MEDIDA(W4)) dut4 (
    .clock(clock), .reset(reset), .medir(medir), .pronto_pulso(pronto_pulso), .echo(echo),
    .gera(gera4), .medida(medida4), .pronto(pronto4), .erro_timeout(erro4),
    .ocupado(ocupado4), .db_estado(db4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural gerador_pulso: pronto_pulso one cycle, 25 cycles after gera.
  initial begin
    pronto_pulso = 1'b0;
    forever begin
      @(negedge clock);
      pronto_pulso = 1'b0;
      if (gera === 1'b1) gen_cnt = 25;
      else if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0) pronto_pulso = 1'b1;
      end
    end
  end

  always @(negedge clock) if (gera === 1'b1) gera_cnt <= gera_cnt + 1;

  // Distance in cm for an echo of n cycles: round half up, saturate at 2^w-1.
  function automatic int modelo(input int n, input int w);
    int cm;
    int mx;
    mx = (1 << w) - 1;
    cm = n / CPM;
    if (cm > mx) cm = mx;
    if ((n % CPM) >= CPM / 2 && cm < mx) cm = cm + 1;
    return cm;
  endfunction

  // One measurement: echo is sampled high on clock edges s..s+len-1 counted
  // from the edge that sees pronto_pulso (edge 0).
  task automatic run_meas(input int s, input int len, input int budget, input int medir_k,
                          output int p0_ok, output int pronto_k, output int erro_k,
                          output int pronto_n, output int busy_viol);
    int n;
    bit fim;
    pronto_k = -1; erro_k = -1; pronto_n = 0; busy_viol = 0; fim = 1'b0;
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    n = 0;
    @(posedge clock);
    while (pronto_pulso !== 1'b1 && n < 100) begin
      @(posedge clock);
      n++;
    end
    p0_ok = (pronto_pulso === 1'b1) ? 1 : 0;
    for (int k = 0; k <= budget; k++) begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        pronto_n++;
        if (pronto_k < 0) pronto_k = k;
      end
      if (erro_timeout === 1'b1 && erro_k < 0) erro_k = k;
      if (!fim && pronto !== 1'b1 && ocupado !== 1'b1) busy_viol++;
      if (pronto === 1'b1 || erro_timeout === 1'b1) fim = 1'b1;
      echo  = (k + 1 >= s && k + 1 < s + len);
      medir = (k + 1 == medir_k);
    end
    echo = 1'b0;
    medir = 1'b0;
    n = 0;
    while (ocupado === 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; echo = 1'b1; medir = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if ({gera, pronto, erro_timeout, ocupado} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {gera, pronto, erro_timeout, ocupado});
    end
    checks++;
    if (medida !== 12'd0) begin errors++; $display("FAIL reset_medida: got %0d expected 0", medida); end
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
    checks++;
    if ({gera4, pronto4, erro4, ocupado4, medida4, db4} !== 12'd0) begin
      errors++; $display("FAIL reset_dut4: got %b expected all 0", {gera4, pronto4, erro4, ocupado4, medida4, db4});
    end
    medir = 1'b0; echo = 1'b0;
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got estado=%0d ocupado=%b expected 0/0", db_estado, ocupado);
    end
  endtask

  task automatic test_nominal();
    int p0, pk, ek, pn, bv, g0;
    g0 = gera_cnt;
    run_meas(20, 57, 85, -1, p0, pk, ek, pn, bv);
    exp_medida = modelo(57, W); exp_medida4 = modelo(57, W4);
    checks++;
    if (p0 != 1) begin errors++; $display("FAIL nom_trigger: pronto_pulso seen=%0d expected 1", p0); end
    checks++;
    if (medida !== W'(exp_medida)) begin errors++; $display("FAIL nom_medida: got %0d expected %0d", medida, exp_medida); end
    checks++;
    if (pn != 1) begin errors++; $display("FAIL nom_pronto_count: got %0d expected 1", pn); end
    // echo_s falls one edge after the raw sample; pronto follows two edges later.
    checks++;
    if (pk != 20 + 57 + 3) begin errors++; $display("FAIL nom_pronto_latency: got %0d expected %0d", pk, 80); end
    checks++;
    if (erro_timeout !== 1'b0) begin errors++; $display("FAIL nom_erro: got %b expected 0", erro_timeout); end
    checks++;
    if (gera_cnt - g0 != 1) begin errors++; $display("FAIL nom_gera_count: got %0d expected 1", gera_cnt - g0); end
  endtask

  task automatic test_rounding();
    int lens[6] = '{54, 50, 55, 9, 5, 4};
    int p0, pk, ek, pn, bv;
    foreach (lens[i]) begin
      run_meas(15, lens[i], 15 + lens[i] + 8, -1, p0, pk, ek, pn, bv);
      exp_medida = modelo(lens[i], W); exp_medida4 = modelo(lens[i], W4);
      checks++;
      if (medida !== W'(exp_medida) || pn != 1) begin
        errors++; $display("FAIL round_len%0d: got medida=%0d pronto_n=%0d expected %0d/1", lens[i], medida, pn, exp_medida);
      end
    end
  endtask

  task automatic test_random();
    int p0, pk, ek, pn, bv, s, len;
    for (int it = 0; it < 8; it++) begin
      s = $urandom_range(40, 1);
      len = $urandom_range(400, 1);
      run_meas(s, len, s + len + 8, -1, p0, pk, ek, pn, bv);
      exp_medida = modelo(len, W); exp_medida4 = modelo(len, W4);
      checks++;
      if (medida !== W'(exp_medida) || medida4 !== W4'(exp_medida4)) begin
        errors++; $display("FAIL rand_len%0d: got %0d/%0d expected %0d/%0d", len, medida, medida4, exp_medida, exp_medida4);
      end
      checks++;
      if (pn != 1 || pk != s + len + 3 || erro_timeout !== 1'b0) begin
        errors++; $display("FAIL rand_strobe_len%0d: got pronto_n=%0d at %0d erro=%b expected 1 at %0d erro=0", len, pn, pk, erro_timeout, s + len + 3);
      end
    end
  endtask

  task automatic test_no_echo();
    int p0, pk, ek, pn, bv;
    run_meas(1, 0, TOUT + 20, -1, p0, pk, ek, pn, bv);
    checks++;
    if (ek != TOUT) begin errors++; $display("FAIL noecho_erro_time: got %0d expected %0d", ek, TOUT); end
    checks++;
    if (pn != 0) begin errors++; $display("FAIL noecho_pronto: got %0d expected 0", pn); end
    repeat (5) @(negedge clock);
    checks++;
    if (erro_timeout !== 1'b1) begin errors++; $display("FAIL noecho_erro_held: got %b expected 1", erro_timeout); end
    checks++;
    if (medida !== W'(exp_medida) || medida4 !== W4'(exp_medida4)) begin
      errors++; $display("FAIL noecho_medida_kept: got %0d/%0d expected %0d/%0d", medida, medida4, exp_medida, exp_medida4);
    end
    run_meas(12, 33, 12 + 33 + 8, -1, p0, pk, ek, pn, bv);
    exp_medida = modelo(33, W); exp_medida4 = modelo(33, W4);
    checks++;
    if (erro_timeout !== 1'b0 || ek != -1 || medida !== W'(exp_medida)) begin
      errors++; $display("FAIL noecho_recover: got erro=%b medida=%0d expected 0/%0d", erro_timeout, medida, exp_medida);
    end
  endtask

  task automatic test_stuck_high();
    int p0, pk, ek, pn, bv;
    run_meas(10, 1000000, TOUT + 20, -1, p0, pk, ek, pn, bv);
    checks++;
    if (ek != TOUT || pn != 0) begin
      errors++; $display("FAIL stuck_high: got erro_at=%0d pronto_n=%0d expected %0d/0", ek, pn, TOUT);
    end
    checks++;
    if (medida !== W'(exp_medida)) begin errors++; $display("FAIL stuck_medida_kept: got %0d expected %0d", medida, exp_medida); end
    // Echo last sampled high on edge TOUT-3, so echo_s falls exactly on the final timeout cycle.
    run_meas(10, TOUT - 2 - 10, TOUT + 20, -1, p0, pk, ek, pn, bv);
    checks++;
    if (ek != TOUT || pn != 0 || erro_timeout !== 1'b1) begin
      errors++; $display("FAIL fall_at_timeout: got erro_at=%0d pronto_n=%0d erro=%b expected %0d/0/1", ek, pn, erro_timeout, TOUT);
    end
  endtask

  task automatic test_saturation_busy();
    int p0, pk, ek, pn, bv, g0;
    g0 = gera_cnt;
    run_meas(5, 200, 213, 55, p0, pk, ek, pn, bv);
    exp_medida = modelo(200, W); exp_medida4 = modelo(200, W4);
    checks++;
    if (medida4 !== W4'(exp_medida4)) begin errors++; $display("FAIL sat_medida4: got %0d expected %0d", medida4, exp_medida4); end
    checks++;
    if (medida !== W'(exp_medida)) begin errors++; $display("FAIL sat_medida12: got %0d expected %0d", medida, exp_medida); end
    checks++;
    if (gera_cnt - g0 != 1 || pn != 1) begin
      errors++; $display("FAIL busy_medir_ignored: got gera=%0d pronto_n=%0d expected 1/1", gera_cnt - g0, pn);
    end
    checks++;
    if (bv != 0) begin errors++; $display("FAIL busy_ocupado: got %0d idle cycles expected 0", bv); end
  endtask

  initial begin
    reset = 1'b0; medir = 1'b0; echo = 1'b0;
    test_reset();
    test_nominal();
    test_rounding();
    test_random();
    test_no_echo();
    test_stuck_high();
    test_saturation_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/medidor_echo.md
Name: medidor_echo

Overview:
Ultrasonic ranging controller that sits directly around the trigger pulse generator (gerador_pulso). On a measurement request it drives the generator's gera input. It then waits for the generator's pronto, times the sensor's echo pulse and converts its width to centimetres. The result goes to the display and serial stages, with a timeout error path when no echo arrives.

Parameters:
CICLOS_POR_CM, 2941, clock cycles of echo high per centimetre (50 MHz, 58.82 us/cm)
TIMEOUT_CICLOS, 1250000, maximum cycles from trigger done to echo fall (25 ms)
LARGURA_MEDIDA, 12, width of the distance output in bits

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low; reset=0 forces initial state
medir  in  1  start request, sampled high for one or more cycles
pronto_pulso  in  1  from gerador_pulso pronto; trigger pulse finished
echo  in  1  sensor echo, asynchronous to clock
gera  out  1  to gerador_pulso gera; one-cycle start strobe
medida  out  LARGURA_MEDIDA  last valid distance in cm
pronto  out  1  one-cycle strobe, new medida valid
erro_timeout  out  1  level, last measurement timed out
ocupado  out  1  high in any state except INICIAL
db_estado  out  4  current state encoding, for debug

Behaviour:
- Reset (reset=0, async): state INICIAL. gera=0, pronto=0, erro_timeout=0, medida=0, all counters 0, synchronizer flops 0.
- echo passes through a 2-FF synchronizer (echo_s). Rise and fall detection use echo_s and its one-cycle delayed copy. Both edges incur the same 2-cycle latency, so measured width is exact.
- State INICIAL (0): idle. medir=1 -> DISPARA, and erro_timeout clears.
- State DISPARA (1): gera=1 for exactly one cycle -> ESPERA_TRIGGER.
- State ESPERA_TRIGGER (2): wait for pronto_pulso=1. pronto_pulso=1 -> ESPERA_ECHO and the timeout counter clears. No timeout applies here; gerador_pulso always finishes.
- State ESPERA_ECHO (3): timeout counter increments every cycle.
  - echo_s rise -> MEDE. Tick counter and cm counter clear.
  - Timeout counter reaches TIMEOUT_CICLOS-1 -> ERRO.
- State MEDE (4): timeout counter keeps running.
  - Tick counter increments each cycle. When it reaches CICLOS_POR_CM-1 it wraps to 0 and the cm counter increments.
  - The cm counter saturates at 2^LARGURA_MEDIDA-1 and does not wrap.
  - echo_s fall -> FINAL.
  - Timeout reached while echo is still high -> ERRO.
  - If fall and timeout occur in the same cycle, timeout wins.
- State FINAL (5):
  - Rounding: medida <= cm + 1 if residual tick >= CICLOS_POR_CM/2 (integer division), else cm. The increment also saturates.
  - pronto=1 for this one cycle -> INICIAL.
- State ERRO (6): erro_timeout=1 (held until the next medir). medida is kept unchanged -> INICIAL. pronto is not asserted.
- medir is ignored outside INICIAL. If medir is held high, a new measurement starts the cycle after returning to INICIAL.
- Echo already high on entry to ESPERA_ECHO produces no rise, so it counts toward the timeout and ends in ERRO.
- Latency: medir to gera = 1 cycle. echo_s fall to pronto = 2 cycles, i.e. raw echo fall to pronto = 4 cycles.
- Unused state encodings -> INICIAL.

Decomposition:
- Shared package holds the state encodings (INICIAL..ERRO, 4-bit) and the default CICLOS_POR_CM / TIMEOUT_CICLOS constants. The serial/display stages reuse them.
- One natural sub-module, contador_cm: tick and cm counters with clear, enable, saturation and rounding output.

Test Plan:
All scenarios use CICLOS_POR_CM=10, TIMEOUT_CICLOS=500, LARGURA_MEDIDA=12 and a behavioural gerador_pulso model with pronto 25 cycles after gera.
- Reset: hold reset=0 with echo=1 and medir=1 -> all outputs 0 and db_estado=0. After reset=1 and medir, a measurement proceeds normally.
- Nominal: medir pulse, then echo high 57 cycles, starting 20 cycles after pronto_pulso -> gera seen exactly once, medida=6 (5.7 rounded), pronto high 1 cycle, erro_timeout=0.
- Round down and exact: echo 54 cycles -> medida=5. Echo 50 cycles -> medida=5.
- No echo: echo held 0 -> ERRO 500 cycles after pronto_pulso. erro_timeout=1, medida keeps its previous value, no pronto. The next medir clears erro_timeout.
- Echo stuck high: echo rises 10 cycles after pronto_pulso and never falls -> ERRO at cycle 500 of the timeout counter. Also case where fall coincides with timeout -> ERRO.
- Saturation and busy: LARGURA_MEDIDA=4 with 200-cycle echo -> medida=15. medir pulses during MEDE are ignored; ocupado=1 throughout.
